// File: rtl/exu_wb_pkg.sv
// exu_wb_pkg -- shared configuration for the execute-stage writeback block.
//
// Holds the wb_sel, ld_size and FSM state encodings as `define constants,
// and the FSM state enum built on those encodings.
//
// The optional load-extension feature is enabled by defining the macro
// EXU_WB_LOAD_EXT_EN.

`ifndef EXU_WB_PKG_DEFS
`define EXU_WB_PKG_DEFS

// Writeback result source (wb_sel)
`define EXU_WB_SEL_NONE    2'd0
`define EXU_WB_SEL_ALU     2'd1
`define EXU_WB_SEL_MEM     2'd2
`define EXU_WB_SEL_PC4     2'd3

// Load size (ld_size)
`define EXU_WB_LD_BYTE     2'd0
`define EXU_WB_LD_HALF     2'd1
`define EXU_WB_LD_WORD     2'd2

// FSM state encodings
`define EXU_WB_ST_IDLE     2'd0
`define EXU_WB_ST_WAIT_MEM 2'd1
`define EXU_WB_ST_WRITE    2'd2

`endif

package exu_wb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = `EXU_WB_ST_IDLE,
      ST_WAIT_MEM = `EXU_WB_ST_WAIT_MEM,
      ST_WRITE    = `EXU_WB_ST_WRITE
   } exu_wb_state_e;

endpackage

// File: rtl/exu_wb_ldext.sv
// exu_wb_ldext -- combinational load lane extraction and extension.
//
// Selects the byte or halfword lane addressed by ld_off from the load
// data word and sign- or zero-extends it to XLEN. Word loads (and the
// unused ld_size encoding) pass mem_r through unmodified.
// Only instantiated when EXU_WB_LOAD_EXT_EN is defined.
//
// Ports:
//   mem_r       in   XLEN  raw load data word
//   ld_size     in   2     0 byte, 1 half, 2 word
//   ld_unsigned in   1     zero-extend when 1, sign-extend when 0
//   ld_off      in   2     byte offset of the load within the word
//   ld_data     out  XLEN  extracted and extended load result

module exu_wb_ldext
   import exu_wb_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic [XLEN-1:0] mem_r,
   input  logic [1:0]      ld_size,
   input  logic            ld_unsigned,
   input  logic [1:0]      ld_off,
   output logic [XLEN-1:0] ld_data
);

   logic [7:0]  byte_lane;
   logic [15:0] half_lane;

   always_comb begin
      byte_lane = mem_r[{ld_off, 3'b000} +: 8];
      // A misaligned halfword (odd offset) drops bit 0 of the offset.
      half_lane = mem_r[{ld_off[1], 4'b0000} +: 16];
      ld_data   = mem_r;
      case (ld_size)
         `EXU_WB_LD_BYTE:
            ld_data = ld_unsigned ? {{(XLEN-8){1'b0}}, byte_lane}
                                  : {{(XLEN-8){byte_lane[7]}}, byte_lane};
         `EXU_WB_LD_HALF:
            ld_data = ld_unsigned ? {{(XLEN-16){1'b0}}, half_lane}
                                  : {{(XLEN-16){half_lane[15]}}, half_lane};
         default:
            ld_data = mem_r;
      endcase
   end

endmodule

// File: rtl/exu_wb.sv
// exu_wb -- execute-stage writeback unit.
//
// Accepts one writeback request at a time from execute, selects the result
// source (ALU, PC+4 or a load returning from memory) and issues a single
// GPR write strobe. Loads wait for mem_r_valid with a timeout that raises
// a one-cycle mem_err and drops the write.
//
// Optional feature: define EXU_WB_LOAD_EXT_EN to extract byte/half lanes
// and sign/zero-extend load data; otherwise load data is written as is.
//
// Ports:
//   clk          in   1       clock, rising edge
//   rst          in   1       asynchronous reset, active low
//   in_valid     in   1       writeback request
//   in_ready     out  1       high only in IDLE
//   wb_sel       in   2       0 NONE, 1 ALU, 2 MEM, 3 PC4
//   rd           in   REG_AW  destination register
//   alu_result   in   XLEN    ALU result
//   pc           in   XLEN    instruction PC
//   ld_size      in   2       load size
//   ld_unsigned  in   1       zero-extend load
//   ld_off       in   2       load byte offset
//   mem_r_valid  in   1       load data valid pulse
//   mem_r        in   XLEN    load data word
//   gpr_w_en     out  1       GPR write strobe (suppressed for rd 0)
//   gpr_w_addr   out  REG_AW  GPR write address (holds last latched)
//   gpr_w_data   out  XLEN    GPR write data (holds last latched)
//   busy         out  1       state is not IDLE
//   mem_err      out  1       one-cycle pulse on load timeout

module exu_wb
   import exu_wb_pkg::*;
#(
   parameter int unsigned XLEN        = 32,
   parameter int unsigned REG_AW      = 5,
   parameter int unsigned MEM_TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [1:0]        wb_sel,
   input  logic [REG_AW-1:0] rd,
   input  logic [XLEN-1:0]   alu_result,
   input  logic [XLEN-1:0]   pc,
   input  logic [1:0]        ld_size,
   input  logic              ld_unsigned,
   input  logic [1:0]        ld_off,
   input  logic              mem_r_valid,
   input  logic [XLEN-1:0]   mem_r,
   output logic              gpr_w_en,
   output logic [REG_AW-1:0] gpr_w_addr,
   output logic [XLEN-1:0]   gpr_w_data,
   output logic              busy,
   output logic              mem_err
);

   localparam int unsigned CNT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

   exu_wb_state_e    state;
   exu_wb_state_e    state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [XLEN-1:0]  ld_data;
   logic             accept;
   logic             mem_timeout;

   assign accept = in_valid && (state == ST_IDLE);

   // Timeout fires at the end of the MEM_TIMEOUT-th waiting cycle, i.e. the
   // edge where the counter would reach MEM_TIMEOUT; a valid pulse in that
   // same cycle takes priority.
   assign mem_timeout = (state == ST_WAIT_MEM) && !mem_r_valid &&
                        (cnt == CNT_W'(MEM_TIMEOUT - 1));

`ifdef EXU_WB_LOAD_EXT_EN
   logic [1:0] ld_size_q;
   logic       ld_unsigned_q;
   logic [1:0] ld_off_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ld_size_q     <= '0;
         ld_unsigned_q <= 1'b0;
         ld_off_q      <= '0;
      end else if (accept && (wb_sel == `EXU_WB_SEL_MEM)) begin
         ld_size_q     <= ld_size;
         ld_unsigned_q <= ld_unsigned;
         ld_off_q      <= ld_off;
      end
   end

   exu_wb_ldext #(
      .XLEN (XLEN)
   ) u_ldext (
      .mem_r       (mem_r),
      .ld_size     (ld_size_q),
      .ld_unsigned (ld_unsigned_q),
      .ld_off      (ld_off_q),
      .ld_data     (ld_data)
   );
`else
   logic unused_ld;

   assign unused_ld = ^{ld_size, ld_unsigned, ld_off};
   assign ld_data   = mem_r;
`endif

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= ST_IDLE;
      else      state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (accept) begin
               case (wb_sel)
                  `EXU_WB_SEL_ALU,
                  `EXU_WB_SEL_PC4: state_nxt = ST_WRITE;
                  `EXU_WB_SEL_MEM: state_nxt = ST_WAIT_MEM;
                  default:         state_nxt = ST_IDLE;
               endcase
            end
         end
         ST_WAIT_MEM: begin
            if (mem_r_valid)      state_nxt = ST_WRITE;
            else if (mem_timeout) state_nxt = ST_IDLE;
         end
         ST_WRITE: state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      in_ready = (state == ST_IDLE);
      busy     = (state != ST_IDLE);
      gpr_w_en = (state == ST_WRITE) && (gpr_w_addr != '0);
   end

   // Datapath: latched address/data, timeout counter, error pulse
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         gpr_w_addr <= '0;
         gpr_w_data <= '0;
         cnt        <= '0;
         mem_err    <= 1'b0;
      end else begin
         mem_err <= mem_timeout;
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  case (wb_sel)
                     `EXU_WB_SEL_ALU: begin
                        gpr_w_addr <= rd;
                        gpr_w_data <= alu_result;
                     end
                     `EXU_WB_SEL_PC4: begin
                        gpr_w_addr <= rd;
                        gpr_w_data <= pc + XLEN'(4);
                     end
                     `EXU_WB_SEL_MEM: begin
                        gpr_w_addr <= rd;
                        cnt        <= '0;
                     end
                     default: ;
                  endcase
               end
            end
            ST_WAIT_MEM: begin
               if (mem_r_valid) gpr_w_data <= ld_data;
               else             cnt        <= cnt + CNT_W'(1);
            end
            default: ;
         endcase
      end
   end

endmodule
